mux8_serializer: RTL and testbench

Parallel-to-serial front end for the 8:1 select path.
- Accepts an 8-bit word over a valid/ready handshake and holds it in a register.
- Steps a 3-bit select counter through all eight positions and drives one bit per accepted output beat on a serial line.
- Sits directly upstream of the 8:1 selector: it produces both the data vector and the select code the selector consumes.

---
 rtl/mux8_pkg.sv | 35 +++
 rtl/mux8_bitsel.sv | 26 ++
 rtl/mux8_serializer.sv | 115 +++++++++++
 tb/tb_mux8_serializer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux8_pkg.sv
// Shared definitions for the 8:1 serializer front end: FSM states, widths
// and the start/end select codes implied by the bit order.
package mux8_pkg;

  localparam int WORD_W = 8;
  localparam int SEL_W  = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // First select code of a word: bit 0 for LSB-first, bit 7 for MSB-first.
  function automatic logic [SEL_W-1:0] sel_start(input bit msb_first);
    logic [SEL_W-1:0] v;
    if (msb_first) begin
      v = 3'd7;
    end else begin
      v = 3'd0;
    end
    return v;
  endfunction

  // Final select code of a word, mirror image of the start code.
  function automatic logic [SEL_W-1:0] sel_end(input bit msb_first);
    logic [SEL_W-1:0] v;
    if (msb_first) begin
      v = 3'd0;
    end else begin
      v = 3'd7;
    end
    return v;
  endfunction

endpackage

// File: rtl/mux8_bitsel.sv
// Purely combinational 8:1 bit selector: picks word[sel].
module mux8_bitsel
  import mux8_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  input  logic [SEL_W-1:0]  sel,
  output logic              bitval
);

  // Explicit 8-way mux so every select code has a defined output.
  always_comb begin
    bitval = 1'b0;
    case (sel)
      3'd0:    bitval = word[0];
      3'd1:    bitval = word[1];
      3'd2:    bitval = word[2];
      3'd3:    bitval = word[3];
      3'd4:    bitval = word[4];
      3'd5:    bitval = word[5];
      3'd6:    bitval = word[6];
      3'd7:    bitval = word[7];
      default: bitval = 1'b0;
    endcase
  end

endmodule

// File: rtl/mux8_serializer.sv
// Parallel-to-serial front end: accepts an 8-bit word over valid/ready,
// then walks a 3-bit select counter across it, one bit per accepted beat.
// The select code is exported so the downstream 8:1 selector can follow it.
module mux8_serializer
  import mux8_pkg::*;
#(
  parameter bit MSB_FIRST  = 1'b0,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [SEL_W-1:0]  sel,
  output logic              sout,
  output logic              sout_valid,
  input  logic              sout_ready,
  output logic              sout_last,
  output logic              busy
);

  localparam logic [SEL_W-1:0] START_SEL = sel_start(MSB_FIRST);
  localparam logic [SEL_W-1:0] END_SEL   = sel_end(MSB_FIRST);

  state_t              state_r;
  state_t              state_s;
  logic [WORD_W-1:0]   word_r;
  logic [WORD_W-1:0]   word_s;
  logic [SEL_W-1:0]    cnt_r;
  logic [SEL_W-1:0]    cnt_s;
  logic [SEL_W-1:0]    cnt_step_s;
  logic                is_shift_s;
  logic                is_last_s;
  logic                sel_bit_s;

  assign is_shift_s = (state_r == SHIFT);
  assign is_last_s  = is_shift_s && (cnt_r == END_SEL);

  // Counter direction follows the bit order; the end value is reached
  // before any wrap, so the natural 3-bit wrap is never used.
  assign cnt_step_s = MSB_FIRST ? (cnt_r - 3'd1) : (cnt_r + 3'd1);

  // A new word may only enter when idle or as the last bit leaves,
  // which gives zero-gap back-to-back words without dropping a bit.
  assign din_ready = !is_shift_s || (is_last_s && sout_ready);

  mux8_bitsel u_bitsel (
    .word   (word_r),
    .sel    (cnt_r),
    .bitval (sel_bit_s)
  );

  assign sel        = cnt_r;
  assign sout_valid = is_shift_s;
  assign sout_last  = is_last_s;
  assign busy       = is_shift_s;
  assign sout       = is_shift_s ? sel_bit_s : IDLE_LEVEL;

  // Next-state, word load and counter stepping for the IDLE/SHIFT FSM.
  always_comb begin
    state_s = state_r;
    word_s  = word_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (din_valid) begin
          word_s  = din;
          cnt_s   = START_SEL;
          state_s = SHIFT;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (sout_ready) begin
          if (is_last_s) begin
            if (din_valid) begin
              word_s  = din;
              cnt_s   = START_SEL;
              state_s = SHIFT;
            end else begin
              // Park the counter on the start code so sel is predictable in IDLE.
              cnt_s   = START_SEL;
              state_s = IDLE;
            end
          end else begin
            cnt_s = cnt_step_s;
          end
        end else begin
          // Stalled beat: hold everything so no bit is lost or repeated.
          state_s = SHIFT;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = START_SEL;
      end
    endcase
  end

  // State, word and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      word_r  <= 8'h00;
      cnt_r   <= START_SEL;
    end else begin
      state_r <= state_s;
      word_r  <= word_s;
      cnt_r   <= cnt_s;
    end
  end

endmodule

// File: tb/tb_mux8_serializer.sv
// Self-checking bench: an LSB-first and an MSB-first instance share the
// same stimulus; a scoreboard queues expected beats at each accept and
// compares them as each beat is consumed.
module tb_mux8_serializer;

  typedef struct packed {
    logic       b;
    logic [2:0] sel;
    logic       last;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = 8'h00;
  logic       dv  = 1'b0;
  logic       sr  = 1'b0;

  logic       rdy0, sout0, valid0, last0, busy0;
  logic [2:0] sel0;
  logic       rdy1, sout1, valid1, last1, busy1;
  logic [2:0] sel1;

  int n_cmp = 0;
  int n_err = 0;

  beat_t q0[$];
  beat_t q1[$];

  always #5 clk = ~clk;

  mux8_serializer #(.MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .din(din), .din_valid(dv), .din_ready(rdy0),
    .sel(sel0), .sout(sout0), .sout_valid(valid0), .sout_ready(sr),
    .sout_last(last0), .busy(busy0)
  );

  mux8_serializer #(.MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .din(din), .din_valid(dv), .din_ready(rdy1),
    .sel(sel1), .sout(sout1), .sout_valid(valid1), .sout_ready(sr),
    .sout_last(last1), .busy(busy1)
  );

  // Scoreboard: pop/compare consumed beats, idle-level checks, then push on accept.
  always @(negedge clk) begin
    beat_t e;
    if (valid0 === 1'b1 && sr === 1'b1) begin
      n_cmp++;
      if (q0.size() == 0) begin
        n_err++;
        $display("FAIL lsb_beat: unexpected beat sel=%0d sout=%0b, required none", sel0, sout0);
      end else begin
        e = q0.pop_front();
        if ({sout0, sel0, last0} !== {e.b, e.sel, e.last}) begin
          n_err++;
          $display("FAIL lsb_beat: got sout=%0b sel=%0d last=%0b, required sout=%0b sel=%0d last=%0b",
                   sout0, sel0, last0, e.b, e.sel, e.last);
        end
      end
    end else if (valid0 === 1'b0) begin
      n_cmp++;
      if (sout0 !== 1'b0) begin
        n_err++;
        $display("FAIL lsb_idle_level: got %0b, required 0", sout0);
      end
    end
    if (valid1 === 1'b1 && sr === 1'b1) begin
      n_cmp++;
      if (q1.size() == 0) begin
        n_err++;
        $display("FAIL msb_beat: unexpected beat sel=%0d sout=%0b, required none", sel1, sout1);
      end else begin
        e = q1.pop_front();
        if ({sout1, sel1, last1} !== {e.b, e.sel, e.last}) begin
          n_err++;
          $display("FAIL msb_beat: got sout=%0b sel=%0d last=%0b, required sout=%0b sel=%0d last=%0b",
                   sout1, sel1, last1, e.b, e.sel, e.last);
        end
      end
    end else if (valid1 === 1'b0) begin
      n_cmp++;
      if (sout1 !== 1'b1) begin
        n_err++;
        $display("FAIL msb_idle_level: got %0b, required 1", sout1);
      end
    end
    if (rst === 1'b0 && dv === 1'b1 && rdy0 === 1'b1) begin
      for (int i = 0; i < 8; i++) begin
        e.b    = din[i];
        e.sel  = 3'(i);
        e.last = (i == 7);
        q0.push_back(e);
      end
    end
    if (rst === 1'b0 && dv === 1'b1 && rdy1 === 1'b1) begin
      for (int i = 0; i < 8; i++) begin
        e.b    = din[7-i];
        e.sel  = 3'(7 - i);
        e.last = (i == 7);
        q1.push_back(e);
      end
    end
  end

  task automatic test_reset;
    rst = 1'b1; dv = 1'b0; sr = 1'b0; din = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({valid0, sout0, rdy0, busy0, sel0} !== {1'b0, 1'b0, 1'b1, 1'b0, 3'd0}) begin
      n_err++;
      $display("FAIL reset_lsb: got valid=%0b sout=%0b ready=%0b busy=%0b sel=%0d, required 0 0 1 0 0",
               valid0, sout0, rdy0, busy0, sel0);
    end
    n_cmp++;
    if ({valid1, sout1, rdy1, busy1, sel1} !== {1'b0, 1'b1, 1'b1, 1'b0, 3'd7}) begin
      n_err++;
      $display("FAIL reset_msb: got valid=%0b sout=%0b ready=%0b busy=%0b sel=%0d, required 0 1 1 0 7",
               valid1, sout1, rdy1, busy1, sel1);
    end
  endtask

  task automatic test_single_word;
    int vcyc = 0;
    int lastcnt = 0;
    @(posedge clk); #1 din = 8'hB2; dv = 1'b1; sr = 1'b1;
    @(posedge clk); #1 dv = 1'b0; din = 8'h00;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (c == 0) begin
        n_cmp++;
        if (valid0 !== 1'b1) begin
          n_err++;
          $display("FAIL first_bit_latency: valid=%0b, required 1", valid0);
        end
      end
      if (valid0 === 1'b1) begin
        vcyc++;
        if (last0 === 1'b1) lastcnt++;
      end else begin
        break;
      end
    end
    n_cmp++;
    if (vcyc != 8 || lastcnt != 1) begin
      n_err++;
      $display("FAIL single_word_len: got %0d beats %0d last, required 8 and 1", vcyc, lastcnt);
    end
    n_cmp++;
    if ({busy0, rdy0, sel0, busy1, sel1} !== {1'b0, 1'b1, 3'd0, 1'b0, 3'd7}) begin
      n_err++;
      $display("FAIL single_word_idle: got busy=%0b ready=%0b sel=%0d busy1=%0b sel1=%0d, required 0 1 0 0 7",
               busy0, rdy0, sel0, busy1, sel1);
    end
  endtask

  task automatic test_back_to_back;
    int vcyc = 0;
    int pulses = 0;
    bit dropped = 1'b0;
    @(posedge clk); #1 din = 8'hB2; dv = 1'b1; sr = 1'b1;
    @(posedge clk); #1 din = 8'h0F;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (valid0 === 1'b1) begin
        vcyc++;
        n_cmp++;
        if (rdy0 !== last0) begin
          n_err++;
          $display("FAIL b2b_ready: got ready=%0b, required %0b at beat %0d", rdy0, last0, vcyc);
        end
        if (rdy0 === 1'b1) pulses++;
        if (pulses == 1 && !dropped) begin
          dropped = 1'b1;
          @(posedge clk); #1 dv = 1'b0; din = 8'h00;
        end
      end else begin
        break;
      end
    end
    n_cmp++;
    if (vcyc != 16 || pulses != 2) begin
      n_err++;
      $display("FAIL b2b_len: got %0d contiguous beats %0d ready pulses, required 16 and 2", vcyc, pulses);
    end
  endtask

  task automatic test_backpressure;
    int vcyc = 0;
    bit stalled = 1'b0;
    @(posedge clk); #1 din = 8'hB2; dv = 1'b1; sr = 1'b1;
    @(posedge clk); #1 dv = 1'b0; din = 8'h00;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (valid0 === 1'b1) begin
        vcyc++;
        n_cmp++;
        if (rdy0 !== (last0 & sr)) begin
          n_err++;
          $display("FAIL bp_ready: got %0b, required %0b", rdy0, last0 & sr);
        end
        if (sel0 === 3'd2 && !stalled) begin
          stalled = 1'b1;
          @(posedge clk); #1 sr = 1'b0;
          for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            if (valid0 === 1'b1) vcyc++;
            n_cmp++;
            if ({valid0, sel0, sout0, rdy0} !== {1'b1, 3'd3, 1'b0, 1'b0}) begin
              n_err++;
              $display("FAIL bp_hold: got valid=%0b sel=%0d sout=%0b ready=%0b, required 1 3 0 0",
                       valid0, sel0, sout0, rdy0);
            end
          end
          @(posedge clk); #1 sr = 1'b1;
        end
      end else begin
        break;
      end
    end
    n_cmp++;
    if (vcyc != 11) begin
      n_err++;
      $display("FAIL bp_len: got %0d valid cycles, required 11", vcyc);
    end
  endtask

  task automatic test_reset_mid_word;
    @(posedge clk); #1 din = 8'hFF; dv = 1'b1; sr = 1'b1;
    @(posedge clk); #1 dv = 1'b0; din = 8'h00;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (sel0 === 3'd3) break;
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 q0.delete(); q1.delete();
    @(negedge clk);
    n_cmp++;
    if ({valid0, busy0, rdy0, sel0, valid1, sel1} !== {1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 3'd7}) begin
      n_err++;
      $display("FAIL mid_reset: got valid=%0b busy=%0b ready=%0b sel=%0d valid1=%0b sel1=%0d, required 0 0 1 0 0 7",
               valid0, busy0, rdy0, sel0, valid1, sel1);
    end
    @(posedge clk); #1 rst = 1'b0; din = 8'h5A; dv = 1'b1;
    @(posedge clk); #1 dv = 1'b0; din = 8'h00;
    @(negedge clk);
    n_cmp++;
    if ({valid0, sel0, valid1, sel1} !== {1'b1, 3'd0, 1'b1, 3'd7}) begin
      n_err++;
      $display("FAIL restart_sel: got valid=%0b sel=%0d valid1=%0b sel1=%0d, required 1 0 1 7",
               valid0, sel0, valid1, sel1);
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (busy0 !== 1'b1) break;
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_word();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d/%0d beats never produced, required 0/0", q0.size(), q1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
